// File: rtl/segdisp_pkg.sv
// Shared definitions for the seven-segment display reader.
//   SEG_0 .. SEG_F : active-low segment codes, bit 0 = a ... bit 6 = g
//   SEG_BLANK      : all segments off
//   rd_state_t     : frame FSM states
//   NDIG_MAX       : largest supported number of multiplexed digits
package segdisp_pkg;

    localparam int unsigned NDIG_MAX = 8;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {COLLECT, HOLD} rd_state_t;

endpackage

// File: rtl/segdisp_reader_if.sv
// Bundle for the display reader: the monitored display bus (seg, an) and the
// recovered-frame valid/ready output with its side flags.
//   slave  : the reader (samples the display bus, drives the frame outputs)
//   master : the environment (drives the display bus and out_ready)
interface segdisp_reader_if #(
    parameter int unsigned NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic              out_ready;
    logic              out_valid;
    logic [4*NDIG-1:0] out_word;
    logic [NDIG-1:0]   out_blank;
    logic [NDIG-1:0]   out_err;
    logic              multi_an;

    modport master (
        output seg, an, out_ready,
        input  out_valid, out_word, out_blank, out_err, multi_an
    );

    modport slave (
        input  seg, an, out_ready,
        output out_valid, out_word, out_blank, out_err, multi_an
    );
endinterface

// File: rtl/seg_to_hex.sv
// Combinational inverse of a hex-to-seven-segment decoder.
//   seg    : active-low segment pattern, bit 0 = a ... bit 6 = g
//   nibble : recovered hex digit (0 for blank or unknown patterns)
//   blank  : pattern is all segments off
//   err    : pattern is not one of the 16 hex codes and not blank
module seg_to_hex
    import segdisp_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        blank  = 1'b0;
        err    = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/segdisp_reader.sv
// Recovers the hex value shown on a multiplexed, active-low seven-segment bus.
// Each digit is captured once its registered pattern has been stable for
// STABLE_CYCLES samples; when every digit has been seen the frame is offered
// on a valid/ready output.
//   clock, n_reset : system clock, synchronous active-low reset
//   bus (slave)    : seg/an display inputs, out_ready in;
//                    out_valid, out_word, out_blank, out_err, multi_an out
module segdisp_reader
    import segdisp_pkg::*;
#(
    parameter int unsigned NDIG          = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic             clock,
    input logic             n_reset,
    segdisp_reader_if.slave bus
);

    if (NDIG < 2 || NDIG > NDIG_MAX || STABLE_CYCLES < 1) begin : g_bad_param
        $error("segdisp_reader: parameter out of range");
    end

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    // Input sample and the sample before it.
    logic [6:0]      s_seg_q, p_seg_q;
    logic [NDIG-1:0] s_an_q, p_an_q;

    logic [CW-1:0] cnt_q, cnt_d;

    logic [4*NDIG-1:0] stg_word_q, stg_word_d;
    logic [NDIG-1:0]   stg_blank_q, stg_blank_d;
    logic [NDIG-1:0]   stg_err_q, stg_err_d;
    logic [NDIG-1:0]   seen_q, seen_d;

    rd_state_t         state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [4*NDIG-1:0] out_word_q;
    logic [NDIG-1:0]   out_blank_q, out_err_q;

    logic [NDIG-1:0] an_low;
    logic            one_low, multi_low, same, capture, load;
    logic [3:0]      dec_nibble;
    logic            dec_blank, dec_err;

    seg_to_hex u_dec (
        .seg    (s_seg_q),
        .nibble (dec_nibble),
        .blank  (dec_blank),
        .err    (dec_err)
    );

    assign an_low    = ~s_an_q;
    assign one_low   = $onehot(an_low);
    assign multi_low = (an_low != '0) && !one_low;
    assign same      = (s_seg_q == p_seg_q) && (s_an_q == p_an_q);

    always_comb begin
        cnt_d = '0;
        if (one_low) begin
            if (!same) begin
                cnt_d = CW'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // A changed pattern restarts the count, so with STABLE_CYCLES == 1 a new
    // pattern must still capture even though the count stays at its maximum.
    assign capture = one_low && (cnt_d == CNT_MAX) && (!same || (cnt_q != CNT_MAX));

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        case (state_q)
            COLLECT: begin
                if (&seen_q) begin
                    load        = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // A capture landing on the load edge survives into the next frame.
    always_comb begin
        stg_word_d  = stg_word_q;
        stg_blank_d = stg_blank_q;
        stg_err_d   = stg_err_q;
        seen_d      = load ? '0 : seen_q;
        if (capture) begin
            for (int i = 0; i < int'(NDIG); i++) begin
                if (an_low[i]) begin
                    stg_word_d[4*i +: 4] = dec_nibble;
                    stg_blank_d[i]       = dec_blank;
                    stg_err_d[i]         = dec_err;
                    seen_d[i]            = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            s_seg_q     <= SEG_BLANK;
            s_an_q      <= '1;
            p_seg_q     <= SEG_BLANK;
            p_an_q      <= '1;
            cnt_q       <= '0;
            stg_word_q  <= '0;
            stg_blank_q <= '0;
            stg_err_q   <= '0;
            seen_q      <= '0;
            state_q     <= COLLECT;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_blank_q <= '0;
            out_err_q   <= '0;
        end else begin
            s_seg_q     <= bus.seg;
            s_an_q      <= bus.an;
            p_seg_q     <= s_seg_q;
            p_an_q      <= s_an_q;
            cnt_q       <= cnt_d;
            stg_word_q  <= stg_word_d;
            stg_blank_q <= stg_blank_d;
            stg_err_q   <= stg_err_d;
            seen_q      <= seen_d;
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (load) begin
                out_word_q  <= stg_word_q;
                out_blank_q <= stg_blank_q;
                out_err_q   <= stg_err_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_blank = out_blank_q;
    assign bus.out_err   = out_err_q;
    assign bus.multi_an  = multi_low;

endmodule

// File: tb/tb_segdisp_reader.sv
// Directed bench for segdisp_reader (NDIG=4, STABLE_CYCLES=4). Inputs are
// driven just after a rising edge or at a falling edge; outputs are sampled
// on falling edges.
module tb_segdisp_reader;

    logic clk;
    logic n_reset;
    int   n_vec;
    int   n_miss;

    segdisp_reader_if #(.NDIG(4)) bus ();

    segdisp_reader #(
        .NDIG          (4),
        .STABLE_CYCLES (4)
    ) dut (
        .clock   (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic show(input int dig, input logic [6:0] pat, input int cyc);
        logic [3:0] a;
        a        = 4'b1111;
        a[dig]   = 1'b0;
        bus.an   = a;
        bus.seg  = pat;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cyc);
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] word,
                               input logic [3:0] blank, input logic [3:0] err);
        @(negedge clk);
        check_eq({tag, "_valid"}, bus.out_valid, 1'b1);
        check_eq({tag, "_word"}, bus.out_word, word);
        check_eq({tag, "_blank"}, bus.out_blank, blank);
        check_eq({tag, "_err"}, bus.out_err, err);
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_eq(tag, bus.out_valid, 1'b0);
    endtask

    initial begin
        logic any_valid;
        n_vec         = 0;
        n_miss        = 0;
        n_reset       = 1'b0;
        bus.an        = 4'b1111;
        bus.seg       = 7'b1111111;
        bus.out_ready = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", bus.out_valid, 1'b0);
        check_eq("rst_word", bus.out_word, 16'h0000);
        check_eq("rst_blank", bus.out_blank, 4'h0);
        check_eq("rst_err", bus.out_err, 4'h0);
        check_eq("rst_multi", bus.multi_an, 1'b0);
        n_reset   = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.multi_an) any_valid = 1'b1;
        end
        check_eq("idle_quiet", any_valid, 1'b0);

        // Frame capture with backpressure: digits F,2,A,1
        show(0, 7'b0001110, 8);
        show(1, 7'b0100100, 8);
        show(2, 7'b0001000, 8);
        show(3, 7'b1111001, 8);
        idle(2);
        check_frame("f1", 16'h1A2F, 4'h0, 4'h0);
        idle(10);
        check_frame("f1_hold", 16'h1A2F, 4'h0, 4'h0);
        handshake("f1_hs");

        // Stability threshold: 3 samples do not capture, 5 do
        show(0, 7'b0010010, 3);
        idle(3);
        show(1, 7'b1000000, 8);
        show(2, 7'b1000000, 8);
        show(3, 7'b1000000, 8);
        idle(4);
        @(negedge clk);
        check_eq("thr_short", bus.out_valid, 1'b0);
        show(0, 7'b0010010, 5);
        idle(4);
        check_frame("thr5", 16'h0005, 4'h0, 4'h0);
        handshake("thr5_hs");

        // Blank and illegal patterns
        show(0, 7'b1111000, 8);
        show(1, 7'b1000110, 8);
        show(2, 7'b1111111, 8);
        show(3, 7'b0101010, 8);
        idle(4);
        check_frame("blk", 16'h00C7, 4'b0100, 4'b1000);
        handshake("blk_hs");

        // Multiple anodes low
        bus.an  = 4'b1100;
        bus.seg = 7'b0000000;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("multi_%0d", i), bus.multi_an, 1'b1);
        end
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        @(negedge clk);
        check_eq("multi_end", bus.multi_an, 1'b0);

        // Overwrite: digit 1 = 3 then 7; digits 0/1 not seen from the multi test
        show(1, 7'b0110000, 8);
        show(2, 7'b0010000, 8);
        show(3, 7'b0000110, 8);
        idle(4);
        @(negedge clk);
        check_eq("ovr_partial", bus.out_valid, 1'b0);
        show(1, 7'b1111000, 8);
        show(0, 7'b1000000, 8);
        idle(4);
        check_frame("ovr", 16'hE970, 4'h0, 4'h0);
        check_eq("ovr_nib1", bus.out_word[7:4], 4'h7);
        handshake("ovr_hs");

        // Reset after three digits discards them
        show(0, 7'b1111001, 8);
        show(1, 7'b0100100, 8);
        show(2, 7'b0110000, 8);
        bus.an  = 4'b1111;
        bus.seg = 7'b1111111;
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rstmid_valid", bus.out_valid, 1'b0);
        check_eq("rstmid_word", bus.out_word, 16'h0000);
        n_reset = 1'b1;
        show(3, 7'b0011001, 8);
        idle(10);
        @(negedge clk);
        check_eq("rstmid_one", bus.out_valid, 1'b0);
        show(0, 7'b0100001, 8);
        show(1, 7'b0000011, 8);
        show(2, 7'b0000010, 8);
        idle(4);
        check_frame("rstmid_new", 16'h46BD, 4'h0, 4'h0);

        // Next frame collected while held: one idle cycle, then reload
        show(0, 7'b1111001, 8);
        show(1, 7'b0100100, 8);
        show(2, 7'b0110000, 8);
        show(3, 7'b0011001, 8);
        idle(2);
        check_frame("b2b_hold", 16'h46BD, 4'h0, 4'h0);
        handshake("b2b_gap");
        @(negedge clk);
        check_eq("b2b_valid", bus.out_valid, 1'b1);
        check_eq("b2b_word", bus.out_word, 16'h4321);
        handshake("b2b_hs");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/segdisp_reader.md
Name: segdisp_reader

Overview:
- Monitors a multiplexed, active-low seven-segment display bus (segment lines plus digit anodes) and recovers the hex value being displayed.
- Inverse of the hex-to-segment decoder: the multiplier's display path can be self-checked in hardware and on the bench.
- Captures each digit once its pattern is stable, assembles a full frame, and presents it on a valid/ready output.

Parameters:
- NDIG, 4, number of multiplexed digits (2..8).
- STABLE_CYCLES, 4, consecutive identical registered samples required before a digit is captured (>=1).

Ports:
- clock  input  1  system clock.
- n_reset  input  1  synchronous, active-low reset.
- seg  input  7  segment lines, active low, bit 0 = segment a … bit 6 = segment g.
- an  input  NDIG  digit enables, active low; an[i] selects digit i.
- out_ready  input  1  consumer accepts the frame.
- out_valid  output  1  frame available.
- out_word  output  4*NDIG  recovered hex; digit i in bits [4i+3:4i].
- out_blank  output  NDIG  digit i displayed all-off (7'b1111111).
- out_err  output  NDIG  digit i showed a pattern outside the 16-code table.
- multi_an  output  1  one-cycle pulse: more than one anode low in the registered sample.

Behaviour:
- Reset (n_reset=0 at a clock edge): out_valid, out_word, out_blank, out_err and multi_an = 0. Staging registers and seen[] = 0. Stability counter = 0. State = COLLECT.
- Input sampling: seg and an are registered once (s_seg, s_an). All decisions use the registered sample.
- Stability counter behaviour:
  - When s_an has exactly one bit low and {s_seg,s_an} equals the previous cycle's sample, cnt increments, saturating at STABLE_CYCLES.
  - When s_an has exactly one bit low but differs from the previous sample, cnt = 1.
  - Otherwise cnt = 0.
- Capture: on the cycle cnt transitions to STABLE_CYCLES, digit i (the low anode) is decoded and written to staging (nibble, blank, err), and seen[i] is set.
  - A further capture of the same digit overwrites it; the last stable value wins.
  - A held pattern captures exactly once until it changes.
- Decode map, seg → nibble:
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7.
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F.
  - 1111111 → nibble 0, blank=1.
  - Any other pattern → nibble 0, err=1.
- All anodes high: cnt=0, no capture, no flag.
- Two or more anodes low: cnt=0, no capture, multi_an=1 for that cycle.
- FSM states:
  - COLLECT: when seen[] becomes all ones, the next edge copies staging to the out_* registers, sets out_valid=1, clears seen[] and enters HOLD.
  - HOLD: out_* remain stable while out_ready=0. Capture into staging continues.
    - On out_valid&out_ready: next edge out_valid=0, state COLLECT.
    - If seen[] is already all ones at handshake, the following edge reloads, giving at most one idle cycle between frames.
- Simultaneous events: a capture that completes seen[] in the same cycle as a HOLD handshake is retained in staging and issued next.
- Reset mid-frame discards staging and any pending frame.
- Minimum latency from a new stable pattern on the pins to capture: STABLE_CYCLES+1 edges.

Decomposition:
- Package segdisp_pkg holds:
  - SEG_0 … SEG_F and SEG_BLANK localparams (7-bit, active low);
  - typedef enum logic {COLLECT, HOLD} rd_state_t;
  - the NDIG upper bound.
- Sub-module seg_to_hex (combinational): input 7-bit seg; outputs nibble[3:0], blank, err. One instance, driven by s_seg.
- The top level holds the sampler, counter, staging, seen[] and FSM.

Test Plan:
- Reset and idle:
  - Stimulus: n_reset=0 for 2 cycles, an=4'b1111.
  - Required: all outputs 0; no out_valid after 50 cycles.
- Frame capture and backpressure:
  - Stimulus: scan digits 0..3 with patterns F,2,A,1 (0001110, 0100100, 0001000, 1111001), each held 8 cycles; out_ready=0.
  - Required: out_valid=1 with out_word=16'h1A2F, out_blank=0, out_err=0, held stable while out_ready=0.
  - Then out_ready=1 for one cycle → out_valid=0 next cycle.
- Stability threshold (STABLE_CYCLES=4):
  - Stimulus: hold digit 0 at 0010010 for 3 cycles, then 4'b1111.
  - Required: seen[0] not set. Holding 5 cycles captures nibble 5.
- Blank and illegal patterns:
  - Stimulus: digit 2 = 1111111, digit 3 = 0101010, others valid.
  - Required: out_blank=4'b0100, out_err=4'b1000, out_word[15:8]=8'h00.
- Multiple anodes:
  - Stimulus: an=4'b1100 for 6 cycles.
  - Required: multi_an pulses each cycle from the cycle after application; no capture, seen unchanged.
- Overwrite and reset mid-frame:
  - Stimulus: capture digit 1 = 3, then digit 1 = 7, complete the frame.
  - Required: out_word[7:4]=7.
  - Stimulus: repeat with n_reset=0 asserted after 3 digits.
  - Required: no frame emitted until 4 fresh captures.
